// File: rtl/opto_period_monitor.sv
// Per-tooth period monitor for the code-disc opto switch: stores tooth periods in a RAM indexed
// by tooth number and reports per-revolution sum, min, max, tooth count, overflow and stall.
module opto_period_monitor #(
   parameter int unsigned CNT_W        = 20,
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned TEETH        = 60,
   parameter int unsigned STALL_CYCLES = 1000000,
   parameter int unsigned SUM_W        = 32
) (
   input  logic              i_clk_50m,
   input  logic              i_rst_n,
   input  logic              i_opto_switch,
   input  logic              i_zero_sign,
   input  logic              i_motor_state,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_ram_raddr,
   input  logic              i_ram_ren,
   output logic [CNT_W-1:0]  o_ram_rdata,
   output logic [SUM_W-1:0]  o_rev_period,
   output logic [CNT_W-1:0]  o_tooth_max,
   output logic [CNT_W-1:0]  o_tooth_min,
   output logic [ADDR_W:0]   o_tooth_cnt,
   output logic              o_tooth_err,
   output logic              o_ovf,
   output logic              o_rev_valid,
   output logic              o_stall
);

   localparam int unsigned     MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned     STALL_M1_I = STALL_CYCLES - 1;
   localparam logic [ADDR_W:0] DEPTH_C    = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] TEETH_C    = TEETH[ADDR_W:0];
   localparam logic [CNT_W-1:0] STALL_C   = STALL_CYCLES[CNT_W-1:0];
   localparam logic [CNT_W-1:0] STALL_M1  = STALL_M1_I[CNT_W-1:0];

   typedef enum logic [1:0] {StIdle, StWaitZero, StRun} state_e;

   state_e            state_q, state_d;
   logic              s1_q, s2_q, s3_q, ed;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stall_q, stall_d, stall_hit;
   logic              zero_pend_q, zero_pend_d, zero_eff;
   logic [SUM_W-1:0]  sum_q, sum_d, sum_new;
   logic [SUM_W:0]    sum_ext;
   logic [CNT_W-1:0]  min_q, min_d, min_new, max_q, max_d, max_new;
   logic [ADDR_W:0]   idx_q, idx_d, tooth_cnt_new;
   logic              ovf_acc_q, ovf_acc_d, ovf_new, in_range;
   logic [SUM_W-1:0]  rev_period_q, rev_period_d;
   logic [CNT_W-1:0]  tooth_min_q, tooth_min_d, tooth_max_q, tooth_max_d;
   logic [ADDR_W:0]   tooth_cnt_q, tooth_cnt_d;
   logic              tooth_err_q, tooth_err_d, ovf_q, ovf_d, rev_valid_q, rev_valid_d;
   logic              ram_we;
   logic [CNT_W-1:0]  mem [DEPTH];
   logic [CNT_W-1:0]  rdata_q;

   assign ed          = s2_q & ~s3_q;
   assign zero_eff    = zero_pend_q | i_zero_sign;
   // Stall asserts in the same cycle the period counter reaches STALL_CYCLES.
   assign stall_hit   = ~ed & (cnt_q >= STALL_M1);
   assign stall_d     = ~ed & (stall_q | stall_hit);
   assign zero_pend_d = ~ed & zero_eff;
   assign cnt_d       = ed ? CNT_W'(1) : ((cnt_q < STALL_C) ? cnt_q + CNT_W'(1) : cnt_q);

   assign sum_ext       = {1'b0, sum_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, cnt_q};
   assign sum_new       = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
   assign min_new       = (cnt_q < min_q) ? cnt_q : min_q;
   assign max_new       = (cnt_q > max_q) ? cnt_q : max_q;
   assign in_range      = idx_q < DEPTH_C;
   assign ovf_new       = ovf_acc_q | ~in_range;
   assign tooth_cnt_new = in_range ? idx_q + (ADDR_W + 1)'(1) : DEPTH_C;

   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      min_d        = min_q;
      max_d        = max_q;
      idx_d        = idx_q;
      ovf_acc_d    = ovf_acc_q;
      rev_period_d = rev_period_q;
      tooth_min_d  = tooth_min_q;
      tooth_max_d  = tooth_max_q;
      tooth_cnt_d  = tooth_cnt_q;
      tooth_err_d  = tooth_err_q;
      ovf_d        = ovf_q;
      rev_valid_d  = 1'b0;
      ram_we       = 1'b0;
      if (i_clr) begin
         state_d      = i_motor_state ? StWaitZero : StIdle;
         sum_d        = '0;
         min_d        = '1;
         max_d        = '0;
         idx_d        = '0;
         ovf_acc_d    = 1'b0;
         rev_period_d = '0;
         tooth_min_d  = '0;
         tooth_max_d  = '0;
         tooth_cnt_d  = '0;
         tooth_err_d  = 1'b0;
         ovf_d        = 1'b0;
      end else if (!i_motor_state) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: state_d = StWaitZero;
            StWaitZero: begin
               // The period ending at the zero edge belongs to no revolution.
               if (ed && zero_eff) begin
                  state_d   = StRun;
                  sum_d     = '0;
                  min_d     = '1;
                  max_d     = '0;
                  idx_d     = '0;
                  ovf_acc_d = 1'b0;
               end
            end
            StRun: begin
               if (ed) begin
                  ram_we = in_range;
                  if (zero_eff) begin
                     rev_period_d = sum_new;
                     tooth_min_d  = min_new;
                     tooth_max_d  = max_new;
                     tooth_cnt_d  = tooth_cnt_new;
                     tooth_err_d  = tooth_cnt_new != TEETH_C;
                     ovf_d        = ovf_new;
                     rev_valid_d  = 1'b1;
                     sum_d        = '0;
                     min_d        = '1;
                     max_d        = '0;
                     idx_d        = '0;
                     ovf_acc_d    = 1'b0;
                  end else begin
                     sum_d     = sum_new;
                     min_d     = min_new;
                     max_d     = max_new;
                     ovf_acc_d = ovf_new;
                     idx_d     = in_range ? idx_q + (ADDR_W + 1)'(1) : idx_q;
                  end
               end else if (stall_hit) begin
                  state_d = StWaitZero;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         state_q      <= StIdle;
         cnt_q        <= '0;
         stall_q      <= 1'b0;
         zero_pend_q  <= 1'b0;
         sum_q        <= '0;
         min_q        <= '1;
         max_q        <= '0;
         idx_q        <= '0;
         ovf_acc_q    <= 1'b0;
         rev_period_q <= '0;
         tooth_min_q  <= '0;
         tooth_max_q  <= '0;
         tooth_cnt_q  <= '0;
         tooth_err_q  <= 1'b0;
         ovf_q        <= 1'b0;
         rev_valid_q  <= 1'b0;
      end else begin
         s1_q         <= i_opto_switch;
         s2_q         <= s1_q;
         s3_q         <= s2_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stall_q      <= stall_d;
         zero_pend_q  <= zero_pend_d;
         sum_q        <= sum_d;
         min_q        <= min_d;
         max_q        <= max_d;
         idx_q        <= idx_d;
         ovf_acc_q    <= ovf_acc_d;
         rev_period_q <= rev_period_d;
         tooth_min_q  <= tooth_min_d;
         tooth_max_q  <= tooth_max_d;
         tooth_cnt_q  <= tooth_cnt_d;
         tooth_err_q  <= tooth_err_d;
         ovf_q        <= ovf_d;
         rev_valid_q  <= rev_valid_d;
      end
   end

   always_ff @(posedge i_clk_50m) begin
      if (ram_we) mem[idx_q[MEM_AW-1:0]] <= cnt_q;
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdata_q <= '0;
      end else if (i_ram_ren) begin
         rdata_q <= ({1'b0, i_ram_raddr} < DEPTH_C) ? mem[i_ram_raddr[MEM_AW-1:0]] : '0;
      end
   end

   assign o_ram_rdata  = rdata_q;
   assign o_rev_period = rev_period_q;
   assign o_tooth_max  = tooth_max_q;
   assign o_tooth_min  = tooth_min_q;
   assign o_tooth_cnt  = tooth_cnt_q;
   assign o_tooth_err  = tooth_err_q;
   assign o_ovf        = ovf_q;
   assign o_rev_valid  = rev_valid_q;
   assign o_stall      = stall_q;

endmodule

// File: tb/tb_opto_period_monitor.sv
// Scoreboard bench for opto_period_monitor: revolution stats and RAM reads are queued at
// stimulus time and checked by a monitor when the DUT presents them.
module tb_opto_period_monitor;

   localparam int unsigned CNT_W = 20;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned TEETH = 8;
   localparam int unsigned STALL = 5000;
   localparam int unsigned SUM_W = 32;

   typedef struct packed {
      logic [SUM_W-1:0] sum;
      logic [CNT_W-1:0] mn;
      logic [CNT_W-1:0] mx;
      logic [ADDR_W:0]  cnt;
      logic             err;
      logic             ovf;
   } rev_t;

   logic              clk = 1'b0;
   logic              rst_n, opto, zero, lock, clr, ren;
   logic [ADDR_W-1:0] raddr;
   logic [CNT_W-1:0]  rdata, tmax, tmin;
   logic [SUM_W-1:0]  rev_period;
   logic [ADDR_W:0]   tcnt;
   logic              terr, ovf, rev_valid, stall;
   logic              rd_pend = 1'b0;

   rev_t              rev_q[$];
   logic [CNT_W-1:0]  ram_q[$];
   int                n_cmp = 0;
   int                n_fail = 0;

   opto_period_monitor #(
      .CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TEETH(TEETH),
      .STALL_CYCLES(STALL), .SUM_W(SUM_W)
   ) dut (
      .i_clk_50m(clk), .i_rst_n(rst_n), .i_opto_switch(opto), .i_zero_sign(zero),
      .i_motor_state(lock), .i_clr(clr), .i_ram_raddr(raddr), .i_ram_ren(ren),
      .o_ram_rdata(rdata), .o_rev_period(rev_period), .o_tooth_max(tmax), .o_tooth_min(tmin),
      .o_tooth_cnt(tcnt), .o_tooth_err(terr), .o_ovf(ovf), .o_rev_valid(rev_valid),
      .o_stall(stall)
   );

   always #10 clk = ~clk;

   always @(posedge clk) rd_pend <= ren;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One tooth: rising edge now, next rising edge p cycles later.
   task automatic tooth(input int p, input bit z, input int zoff, input bit c);
      for (int i = 0; i < p; i++) begin
         opto = (i < p / 2);
         zero = z && (i == zoff);
         clr  = c && (i == zoff);
         cyc();
      end
      zero = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic exp_rev(input int s, input int mn, input int mx, input int n, input bit e,
                          input bit o);
      rev_t r;
      r.sum = SUM_W'(s);
      r.mn  = CNT_W'(mn);
      r.mx  = CNT_W'(mx);
      r.cnt = (ADDR_W + 1)'(n);
      r.err = e;
      r.ovf = o;
      rev_q.push_back(r);
   endtask

   task automatic rd(input int a, input int exp);
      ram_q.push_back(CNT_W'(exp));
      ren   = 1'b1;
      raddr = ADDR_W'(a);
      cyc();
      ren   = 1'b0;
   endtask

   task automatic chk_stats(input string tag, input int s, input int mn, input int mx,
                            input int n);
      chk({tag, "_period"}, 64'(rev_period), 64'(s));
      chk({tag, "_min"}, 64'(tmin), 64'(mn));
      chk({tag, "_max"}, 64'(tmax), 64'(mx));
      chk({tag, "_cnt"}, 64'(tcnt), 64'(n));
   endtask

   // Monitor: compare whatever the DUT presents against the queued expectations.
   initial begin
      rev_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (rev_valid) begin
               if (rev_q.size() == 0) begin
                  chk("rev_valid_unexpected", 64'(rev_valid), 64'(0));
               end else begin
                  e = rev_q.pop_front();
                  chk("rev_period", 64'(rev_period), 64'(e.sum));
                  chk("tooth_min", 64'(tmin), 64'(e.mn));
                  chk("tooth_max", 64'(tmax), 64'(e.mx));
                  chk("tooth_cnt", 64'(tcnt), 64'(e.cnt));
                  chk("tooth_err", 64'(terr), 64'(e.err));
                  chk("ovf", 64'(ovf), 64'(e.ovf));
               end
            end
            if (rd_pend) begin
               if (ram_q.size() == 0) chk("ram_read_unexpected", 64'(rd_pend), 64'(0));
               else chk("ram_rdata", 64'(rdata), 64'(ram_q.pop_front()));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; opto = 1'b0; zero = 1'b0; lock = 1'b0; clr = 1'b0; ren = 1'b0;
      raddr = '0;
      repeat (5) @(posedge clk);
      #1;
      chk_stats("reset", 0, 0, 0, 0);
      chk("reset_err", 64'(terr), 64'(0));
      chk("reset_ovf", 64'(ovf), 64'(0));
      chk("reset_valid", 64'(rev_valid), 64'(0));
      chk("reset_stall", 64'(stall), 64'(0));
      chk("reset_rdata", 64'(rdata), 64'(0));
      rst_n = 1'b1;
      cyc();
      lock = 1'b1;
      repeat (2) cyc();

      // Uniform 1000-cycle teeth.
      tooth(1000, 1, 0, 0);
      repeat (7) tooth(1000, 0, 0, 0);
      exp_rev(8000, 1000, 1000, 8, 0, 0);

      // Tooth 3 long, tooth 4 short.
      tooth(1000, 1, 0, 0);
      repeat (2) tooth(1000, 0, 0, 0);
      tooth(1200, 0, 0, 0);
      tooth(800, 0, 0, 0);
      repeat (3) tooth(1000, 0, 0, 0);
      exp_rev(8000, 800, 1200, 8, 0, 0);
      fork
         tooth(700, 1, 0, 0);
         begin
            repeat (20) cyc();
            rd(3, 1200);
            rd(4, 800);
            rd(2, 1000);
         end
      join

      // 20 teeth without zero: table overflows at DEPTH.
      repeat (15) tooth(1000, 0, 0, 0);
      repeat (4) tooth(300, 0, 0, 0);
      exp_rev(16900, 300, 1000, 16, 1, 1);
      fork
         tooth(500, 1, 0, 0);
         begin
            repeat (20) cyc();
            rd(0, 700);
            rd(15, 1000);
            rd(14, 1000);
         end
      join

      // Stall mid-revolution.
      tooth(500, 0, 0, 0);
      opto = 1'b1;
      repeat (STALL + 1) cyc();
      chk("stall_early", 64'(stall), 64'(0));
      cyc();
      chk("stall_set", 64'(stall), 64'(1));
      chk("stall_hold_period", 64'(rev_period), 64'(16900));
      opto = 1'b0;
      repeat (10) cyc();
      opto = 1'b1;
      repeat (2) cyc();
      chk("stall_before_ed", 64'(stall), 64'(1));
      cyc();
      chk("stall_cleared", 64'(stall), 64'(0));
      repeat (100) cyc();
      opto = 1'b0;
      repeat (100) cyc();
      repeat (2) tooth(400, 0, 0, 0);
      tooth(300, 1, 0, 0);
      repeat (7) tooth(300, 0, 0, 0);
      exp_rev(2400, 300, 300, 8, 0, 0);

      // Motor unlock mid-revolution.
      tooth(300, 1, 0, 0);
      tooth(600, 0, 0, 0);
      lock = 1'b0;
      tooth(600, 1, 0, 0);
      tooth(600, 0, 0, 0);
      chk_stats("unlocked_hold", 2400, 300, 300, 8);
      rd(1, 300);
      rd(0, 300);
      repeat (3) cyc();
      lock = 1'b1;
      cyc();
      tooth(200, 0, 0, 0);
      tooth(200, 1, 0, 0);
      tooth(250, 0, 0, 0);
      repeat (5) tooth(200, 0, 0, 0);
      tooth(150, 0, 0, 0);
      exp_rev(1600, 150, 250, 8, 0, 0);

      // Zero coincident with the closing edge, then clear coincident with an edge.
      tooth(200, 1, 2, 0);
      repeat (7) tooth(200, 0, 0, 0);
      tooth(200, 1, 2, 1);
      chk_stats("after_clr", 0, 0, 0, 0);
      chk("after_clr_ovf", 64'(ovf), 64'(0));
      tooth(200, 1, 0, 0);
      repeat (7) tooth(200, 0, 0, 0);
      exp_rev(1600, 200, 200, 8, 0, 0);
      tooth(200, 1, 0, 0);

      repeat (20) cyc();
      chk("rev_queue_drained", 64'(rev_q.size()), 64'(0));
      chk("ram_queue_drained", 64'(ram_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/opto_period_monitor.md
Name: opto_period_monitor

Overview:
Parametrised successor to the single-purpose cycle-statistics block in the rotating subsystem. Measures the clock-cycle period of every code-disc tooth from the filtered opto-switch signal and stores per-tooth periods in an internal RAM indexed by tooth number, rezeroed by the zero sign. Produces per-revolution sum, minimum, maximum and tooth count, a tooth-count error flag, a table overflow flag and a stall timeout. Sits beside encoder generation; the RAM is read by the upload/report logic.

Parameters:
CNT_W, 20, period counter width; must hold STALL_CYCLES
DEPTH, 64, RAM entries (max teeth per revolution recorded)
ADDR_W, 6, RAM address width, clog2(DEPTH)
TEETH, 60, nominal teeth per revolution for error check
STALL_CYCLES, 1000000, period saturation / stall threshold in clocks (20 ms)
SUM_W, 32, revolution sum width

Ports:
i_clk_50m  in  1  system clock, 50 MHz
i_rst_n  in  1  asynchronous active-low reset
i_opto_switch  in  1  filtered code-disc signal (asynchronous to clock)
i_zero_sign  in  1  one-cycle zero-tooth pulse
i_motor_state  in  1  1 = speed locked
i_clr  in  1  synchronous clear of statistics, one cycle
i_ram_raddr  in  ADDR_W  RAM read address
i_ram_ren  in  1  RAM read enable
o_ram_rdata  out  CNT_W  RAM read data, registered
o_rev_period  out  SUM_W  sum of tooth periods, last complete revolution
o_tooth_max  out  CNT_W  largest tooth period, last revolution
o_tooth_min  out  CNT_W  smallest tooth period, last revolution
o_tooth_cnt  out  ADDR_W+1  teeth counted, last revolution
o_tooth_err  out  1  o_tooth_cnt != TEETH
o_ovf  out  1  last revolution exceeded DEPTH teeth
o_rev_valid  out  1  one-cycle pulse, revolution stats updated
o_stall  out  1  no edge for STALL_CYCLES clocks

Behaviour:
- Reset: all outputs 0, o_tooth_min 0; state IDLE; RAM contents undefined.
- Edge detect: 2-flop synchroniser plus third flop; ed = s2 & ~s3. Pin high first sampled at cycle t -> ed in cycle t+2.
- Period counter: on ed cnt<=1, else cnt<=cnt+1 saturating at STALL_CYCLES. Edges at cycles a, b -> period = b-a (value of cnt at b).
- zero_pending: set by i_zero_sign, cleared at the next ed. i_zero_sign coincident with ed applies to that ed.
- States:
  IDLE: i_motor_state=0. No RAM writes; outputs hold. i_motor_state=1 -> WAIT_ZERO.
  WAIT_ZERO: on ed with zero_pending -> RUN, idx<=0, accumulators reset (sum 0, max 0, min all-ones); period ending at this edge discarded.
  RUN: on ed: write period to RAM[idx] if idx<DEPTH, else set ovf_acc; sum += period (saturate at 2^SUM_W-1); update min/max. If zero_pending: latch o_rev_period, o_tooth_min, o_tooth_max, o_tooth_cnt=idx+1 (saturate at DEPTH), o_tooth_err, o_ovf=ovf_acc, including this period, on the same clock edge; pulse o_rev_valid in the following cycle; reset accumulators; idx<=0. Else idx<=idx+1 (saturates at DEPTH).
- i_motor_state falling in any state -> IDLE immediately; revolution in progress aborted; outputs hold.
- Stall: cnt reaching STALL_CYCLES sets o_stall; RUN -> WAIT_ZERO (revolution aborted, no o_rev_valid). o_stall clears on the next ed; that period is discarded.
- i_clr: stats outputs and accumulators to reset values, state -> WAIT_ZERO if locked else IDLE; RAM not cleared. i_clr beats a simultaneous ed.
- RAM read: o_ram_rdata <= RAM[i_ram_raddr] one cycle after i_ram_ren=1; holds when ren=0. Read/write same address same cycle returns old data. Addresses >= DEPTH return 0.

Test Plan:
- Params TEETH=8, DEPTH=16; lock, square wave with 1000-cycle period, zero every 8 edges -> after first full rev o_rev_period=8000, min=max=1000, o_tooth_cnt=8, o_tooth_err=0, one o_rev_valid pulse.
- Same, tooth 3 period 1200, tooth 4 800 -> RAM[3]=1200, RAM[4]=800 via read port (1-cycle latency), min=800, max=1200, sum=8000.
- Zero omitted for 20 edges with DEPTH=16 -> at next zero o_ovf=1, o_tooth_cnt=16, RAM[16+] not written, o_tooth_err=1.
- STALL_CYCLES=5000, stop edges mid-rev -> o_stall rises exactly 5000 cycles after last ed, no o_rev_valid; resume -> o_stall clears at first ed, stats restart only after next zero.
- Drop i_motor_state mid-rev -> no RAM writes, outputs hold; relock -> WAIT_ZERO, first rev stats correct.
- i_zero_sign same cycle as ed, and i_clr same cycle as ed -> zero applied to that edge; i_clr wins, outputs zero.
